// File: rtl/regfile_sb.sv
// regfile_sb: integer register file for the pipelined core. It has a busy
// scoreboard so decode can detect RAW and WAW hazards.
//
// Register 0 always reads as zero and writes to it are discarded. There are
// two combinational read ports and one synchronous writeback port. The
// writeback can optionally be forwarded to the read ports in the same cycle.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous reset, active low
//   rd_addr1/rd_addr2   read addresses
//   rd_data1/rd_data2   read data (combinational)
//   iss_valid           decode requests issue
//   iss_use1/iss_use2   issuing instruction reads rd_addr1 / rd_addr2
//   iss_wr/iss_rd       issuing instruction writes destination iss_rd
//   iss_ready           issue accepted this cycle (no hazard)
//   wb_en/wb_addr/wb_data  writeback strobe, address, data
//   busy_vec            bit i set = register i has a pending write
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter int unsigned BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [XLEN-1:0]  rd_data1,
  output logic [XLEN-1:0]  rd_data2,
  input  logic             iss_valid,
  input  logic             iss_use1,
  input  logic             iss_use2,
  input  logic             iss_wr,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] busy_eff;
  logic             raw;
  logic             waw;

  // Storage. Entry 0 is never written, and the read mux masks it anyway.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs <= '{default: '0};
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read ports. Address 0 is handled before the bypass check, so a discarded
  // write to x0 is never forwarded.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == '0) begin
      rd_data1 = '0;
    end else if ((BYPASS != 0) && wb_en && (wb_addr == rd_addr1)) begin
      rd_data1 = wb_data;
    end
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == '0) begin
      rd_data2 = '0;
    end else if ((BYPASS != 0) && wb_en && (wb_addr == rd_addr2)) begin
      rd_data2 = wb_data;
    end
  end

  // Hazard view of the scoreboard. With bypass, a register that completes
  // writeback this cycle is already readable, so it no longer blocks issue.
  // Without bypass, the register blocks issue until the stored copy updates.
  always_comb begin
    wb_hit = '0;
    if (wb_en) begin
      wb_hit[wb_addr] = 1'b1;
    end
    busy_eff = (BYPASS != 0) ? (busy & ~wb_hit) : busy;
  end

  always_comb begin
    raw       = (iss_use1 && busy_eff[rd_addr1]) || (iss_use2 && busy_eff[rd_addr2]);
    waw       = iss_wr && busy_eff[iss_rd];
    iss_ready = iss_valid && !raw && !waw;
  end

  // The set is applied after the clear. A new writer issued in the same
  // cycle as the old writer's writeback therefore stays outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wb_en && (wb_addr != '0)) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (iss_ready && iss_wr && (iss_rd != '0)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb. DUT a (BYPASS=1) and DUT b (BYPASS=0) share the
// same stimulus. DUT c is a 64-bit, 16-register instance. A directed vector
// table and randomized traffic are checked against a reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the 32x32 instances.
  logic        reset, iv, u1, u2, iw, we;
  logic [4:0]  ra1, ra2, ird, wa;
  logic [31:0] wd;
  logic [31:0] rd1a, rd2a, rd1b, rd2b, busya, busyb;
  logic        rdya, rdyb;

  // 64x16 instance.
  logic        c_reset, c_iv, c_u1, c_u2, c_iw, c_we;
  logic [3:0]  c_ra1, c_ra2, c_ird, c_wa;
  logic [63:0] c_wd, c_rd1, c_rd2;
  logic        c_rdy;
  logic [15:0] c_busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr1(ra1), .rd_addr2(ra2),
    .rd_data1(rd1a), .rd_data2(rd2a), .iss_valid(iv), .iss_use1(u1),
    .iss_use2(u2), .iss_wr(iw), .iss_rd(ird), .iss_ready(rdya),
    .wb_en(we), .wb_addr(wa), .wb_data(wd), .busy_vec(busya));

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr1(ra1), .rd_addr2(ra2),
    .rd_data1(rd1b), .rd_data2(rd2b), .iss_valid(iv), .iss_use1(u1),
    .iss_use2(u2), .iss_wr(iw), .iss_rd(ird), .iss_ready(rdyb),
    .wb_en(we), .wb_addr(wa), .wb_data(wd), .busy_vec(busyb));

  regfile_sb #(.XLEN(64), .NREGS(16), .BYPASS(1)) dut_c (
    .clk(clk), .reset(c_reset), .rd_addr1(c_ra1), .rd_addr2(c_ra2),
    .rd_data1(c_rd1), .rd_data2(c_rd2), .iss_valid(c_iv), .iss_use1(c_u1),
    .iss_use2(c_u2), .iss_wr(c_iw), .iss_rd(c_ird), .iss_ready(c_rdy),
    .wb_en(c_we), .wb_addr(c_wa), .wb_data(c_wd), .busy_vec(c_busy));

  // Reference model: architectural contents, plus one pending-writer flag
  // per register for each bypass flavour.
  logic [31:0] m_regs [32];
  bit   [31:0] mb_a, mb_b;

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we && wa == a) return wd;
    return m_regs[a];
  endfunction

  // With bypass, a register whose writeback lands this cycle is already free.
  function automatic bit blocked(input bit [31:0] b, input logic [4:0] r, input bit byp);
    if (!b[r]) return 1'b0;
    if (byp && we && wa == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_ready(input bit [31:0] b, input bit byp);
    if (!iv) return 1'b0;
    if (u1 && blocked(b, ra1, byp)) return 1'b0;
    if (u2 && blocked(b, ra2, byp)) return 1'b0;
    if (iw && blocked(b, ird, byp)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    bit ra, rb;
    ra = exp_ready(mb_a, 1'b1);
    rb = exp_ready(mb_b, 1'b0);
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      mb_a = '0;
      mb_b = '0;
    end else begin
      if (we && wa != 5'd0) begin
        m_regs[wa] = wd;
        mb_a[wa] = 1'b0;
        mb_b[wa] = 1'b0;
      end
      if (ra && iw && ird != 5'd0) mb_a[ird] = 1'b1;
      if (rb && iw && ird != 5'd0) mb_b[ird] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_ab();
    reset = 1'b1; iv = 1'b0; u1 = 1'b0; u2 = 1'b0; iw = 1'b0; we = 1'b0;
    ra1 = '0; ra2 = '0; ird = '0; wa = '0; wd = '0;
  endtask

  task automatic idle_c();
    c_reset = 1'b1; c_iv = 1'b0; c_u1 = 1'b0; c_u2 = 1'b0; c_iw = 1'b0; c_we = 1'b0;
    c_ra1 = '0; c_ra2 = '0; c_ird = '0; c_wa = '0; c_wd = '0;
  endtask

  task automatic check_model();
    chk("rd1_a", 64'(rd1a), 64'(exp_read(ra1, 1'b1)));
    chk("rd2_a", 64'(rd2a), 64'(exp_read(ra2, 1'b1)));
    chk("rd1_b", 64'(rd1b), 64'(exp_read(ra1, 1'b0)));
    chk("rd2_b", 64'(rd2b), 64'(exp_read(ra2, 1'b0)));
    chk("rdy_a", 64'(rdya), 64'(exp_ready(mb_a, 1'b1)));
    chk("rdy_b", 64'(rdyb), 64'(exp_ready(mb_b, 1'b0)));
    chk("busy_a", 64'(busya), 64'(mb_a));
    chk("busy_b", 64'(busyb), 64'(mb_b));
  endtask

  typedef struct {
    logic        rst;
    logic [4:0]  ra1, ra2;
    logic        iv, u1, u2, iw;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e1a, e1b, e2a, e2b;
    logic        rya, ryb;
    logic [31:0] ba, bb;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int q[$];
    // Each row: stimulus, then the expected outputs before the clock edge.
    tbl[0]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 5, 32'h12345678, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[3]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,
                32'h12345678, 32'h12345678, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{1, 5, 7, 1, 0, 0, 0, 0, 1, 7, 32'hA5A5A5A5,
                32'h12345678, 32'h12345678, 32'hA5A5A5A5, 0, 1, 1, 0, 0};
    tbl[5]  = '{1, 5, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,
                32'h12345678, 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 1, 3, 0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 0, 0};
    tbl[7]  = '{1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h8, 32'h8};
    tbl[8]  = '{1, 3, 0, 1, 1, 0, 0, 0, 1, 3, 32'h33,       32'h33, 0, 0, 0, 1, 0, 32'h8, 32'h8};
    tbl[9]  = '{1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h33, 32'h33, 0, 0, 1, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 1, 0, 0, 1, 9, 0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 1, 0, 0, 1, 9, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h200, 32'h200};
    tbl[12] = '{1, 0, 9, 1, 0, 0, 1, 9, 1, 9, 32'h99,       0, 0, 32'h99, 0, 1, 0, 32'h200, 32'h200};
    tbl[13] = '{1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h99, 32'h99, 1, 1, 32'h200, 0};
    tbl[14] = '{0, 0, 0, 1, 0, 0, 1, 4, 1, 5, 32'hFFFF,     0, 0, 0, 0, 1, 1, 32'h200, 0};
    tbl[15] = '{1, 5, 9, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 0, 0};

    idle_ab();
    idle_c();
    reset = 1'b0;
    c_reset = 1'b0;
    step();
    step();
    #1;
    chk("reset_busy_a", 64'(busya), 64'd0);
    chk("reset_rdy_a", 64'(rdya), 64'd0);
    idle_ab();
    idle_c();

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst; ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      iv = tbl[i].iv; u1 = tbl[i].u1; u2 = tbl[i].u2; iw = tbl[i].iw;
      ird = tbl[i].ird; we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      #1;
      chk($sformatf("t%0d_rd1_a", i), 64'(rd1a), 64'(tbl[i].e1a));
      chk($sformatf("t%0d_rd1_b", i), 64'(rd1b), 64'(tbl[i].e1b));
      chk($sformatf("t%0d_rd2_a", i), 64'(rd2a), 64'(tbl[i].e2a));
      chk($sformatf("t%0d_rd2_b", i), 64'(rd2b), 64'(tbl[i].e2b));
      chk($sformatf("t%0d_rdy_a", i), 64'(rdya), 64'(tbl[i].rya));
      chk($sformatf("t%0d_rdy_b", i), 64'(rdyb), 64'(tbl[i].ryb));
      chk($sformatf("t%0d_busy_a", i), 64'(busya), 64'(tbl[i].ba));
      chk($sformatf("t%0d_busy_b", i), 64'(busyb), 64'(tbl[i].bb));
      step();
    end
    idle_ab();

    // 64-bit, 16-register instance: write/read and RAW stall.
    c_we = 1'b1; c_wa = 4'd4; c_wd = 64'hFEDCBA9876543210; c_ra1 = 4'd4;
    #1;
    chk("c_bypass_rd1", c_rd1, 64'hFEDCBA9876543210);
    step();
    idle_c();
    c_ra1 = 4'd4;
    #1;
    chk("c_read_rd1", c_rd1, 64'hFEDCBA9876543210);
    c_we = 1'b1; c_wa = 4'd15; c_wd = 64'h0123456789ABCDEF; c_ra2 = 4'd15;
    step();
    idle_c();
    c_ra2 = 4'd15;
    #1;
    chk("c_read_r15", c_rd2, 64'h0123456789ABCDEF);
    c_iv = 1'b1; c_iw = 1'b1; c_ird = 4'd3;
    #1;
    chk("c_issue_wr3", 64'(c_rdy), 64'd1);
    step();
    idle_c();
    c_iv = 1'b1; c_u1 = 1'b1; c_ra1 = 4'd3;
    #1;
    chk("c_raw_stall", 64'(c_rdy), 64'd0);
    chk("c_busy3", 64'(c_busy), 64'h8);
    step();
    #1;
    chk("c_raw_stall2", 64'(c_rdy), 64'd0);
    c_we = 1'b1; c_wa = 4'd3; c_wd = 64'hFEDCBA9876543210;
    #1;
    chk("c_raw_release", 64'(c_rdy), 64'd1);
    chk("c_raw_fwd", c_rd1, 64'hFEDCBA9876543210);
    step();
    c_we = 1'b0;
    #1;
    chk("c_busy_clear", 64'(c_busy), 64'd0);
    chk("c_rd1_after", c_rd1, 64'hFEDCBA9876543210);
    idle_c();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      ra1 = (n % 5 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      iv  = ($urandom_range(0, 3) != 0);
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      iw  = 1'($urandom_range(0, 1));
      ird = 5'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      q.delete();
      for (int i = 0; i < 32; i++) if (mb_a[i] || mb_b[i]) q.push_back(i);
      if (q.size() != 0 && $urandom_range(0, 3) != 0)
        wa = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        wa = 5'($urandom_range(0, 31));
      #1;
      check_model();
      step();
    end

    // Random writes, then two reset cycles: everything reads zero.
    idle_ab();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = $urandom | 32'h1;
      iv = 1'b1; iw = 1'b1; ird = 5'(i);
      step();
    end
    idle_ab();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rd1_a_%0d", i), 64'(rd1a), 64'd0);
      chk($sformatf("rst_rd2_b_%0d", i), 64'(rd2b), 64'd0);
    end
    chk("rst_busy_a", 64'(busya), 64'd0);
    chk("rst_busy_b", 64'(busyb), 64'd0);
    iv = 1'b1;
    #1;
    chk("rst_ready_a", 64'(rdya), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
